// File: rtl/sr_cmd_gen_if.sv
// sr_cmd_gen_if -- button/pulse bundle for the RS command generator.
//   btn_s, btn_r     : raw asynchronous push-button levels (into the generator)
//   s, r             : one-cycle set/reset pulses to the downstream RS flip-flop
//   conflict, overrun: sticky status flags
// master = button/monitor side, slave = generator side.
interface sr_cmd_gen_if;
  logic btn_s;
  logic btn_r;
  logic s;
  logic r;
  logic conflict;
  logic overrun;

  modport master (output btn_s, btn_r, input s, r, conflict, overrun);
  modport slave  (input btn_s, btn_r, output s, r, conflict, overrun);
endinterface

// File: rtl/sr_cmd_gen.sv
// sr_cmd_gen -- debounced push-button to RS pulse generator.
// Each button is synchronised (2 flops), debounced, and its rising debounced
// edge latches a pending request. A small FSM issues one-cycle s/r pulses,
// set before reset, with GAP_CYCLES idle cycles forced after every pulse.
// Ports:
//   clk : clock, all state on posedge
//   rst : asynchronous active-high reset
//   bus : sr_cmd_gen_if.slave (btn_s/btn_r in, s/r/conflict/overrun out)
module sr_cmd_gen #(
  parameter int DB_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input logic          clk,
  input logic          rst,
  sr_cmd_gen_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PULSE_S = 2'd1;
  localparam logic [1:0] ST_PULSE_R = 2'd2;
  localparam logic [1:0] ST_GAP     = 2'd3;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  // Channel index 0 = set, 1 = reset.
  logic [1:0]            w_btn;
  logic [1:0]            r_sync1, r_sync2;
  logic [1:0]            r_lvl, r_lvl_d;
  logic [1:0][CNT_W-1:0] r_db_cnt;
  logic [1:0]            r_pend;
  logic [1:0]            w_rise, w_take;
  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_gap_cnt;
  logic                  r_conflict, r_overrun;
  logic                  w_idle;

  assign w_btn  = {bus.btn_r, bus.btn_s};
  assign w_rise = r_lvl & ~r_lvl_d;
  assign w_idle = (r_state == ST_IDLE);
  // Set has priority; reset is only taken when set is not pending.
  assign w_take[0] = w_idle & r_pend[0];
  assign w_take[1] = w_idle & ~r_pend[0] & r_pend[1];

  // Synchroniser and debounce. The counter tracks how long sync2 has
  // disagreed with the debounced level; agreement restarts it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_lvl    <= '0;
      r_lvl_d  <= '0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      r_lvl_d <= r_lvl;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_lvl[i]    <= ~r_lvl[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Pending bits and sticky flags. A debounced rise that finds its pending
  // bit already set (pre-edge value) is dropped and flagged as overrun,
  // even if the FSM happens to consume the old request on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= '0;
      r_conflict <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_take[i])                     r_pend[i] <= 1'b0;
        else if (w_rise[i] && !r_pend[i])  r_pend[i] <= 1'b1;
      end
      if (|(w_rise & r_pend))   r_overrun  <= 1'b1;
      if (w_idle && (&r_pend))  r_conflict <= 1'b1;
    end
  end

  // Pulse FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_gap_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_take[0])      r_state <= ST_PULSE_S;
          else if (w_take[1]) r_state <= ST_PULSE_R;
        end
        ST_PULSE_S, ST_PULSE_R: begin
          r_state   <= ST_GAP;
          r_gap_cnt <= '0;
        end
        default: begin
          if (r_gap_cnt == GAP_LAST) r_state <= ST_IDLE;
          else                       r_gap_cnt <= r_gap_cnt + 1'b1;
        end
      endcase
    end
  end

  assign bus.s        = (r_state == ST_PULSE_S);
  assign bus.r        = (r_state == ST_PULSE_R);
  assign bus.conflict = r_conflict;
  assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb_sr_cmd_gen -- self-checking bench for sr_cmd_gen.
// Table of directed scenarios (edge-indexed from reset release), hand-written
// abort/overrun sequences, then random button activity against a reference
// model that works on sampled-input history and pulse scheduling times.
module tb_sr_cmd_gen;

  localparam int DB  = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sr_cmd_gen_if bus1();
  sr_cmd_gen_if bus2();

  sr_cmd_gen #(.DB_CYCLES(DB), .GAP_CYCLES(GAP), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  // Long-gap, short-debounce instance: the only way to make a request wait
  // long enough for a second edge of the same channel to hit it.
  sr_cmd_gen #(.DB_CYCLES(2), .GAP_CYCLES(12), .CNT_W(8)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Leaves the bench #1 after a posedge with rst low; next posedge is edge 0.
  task automatic do_rst();
    bus1.btn_s = 1'b0; bus1.btn_r = 1'b0;
    bus2.btn_s = 1'b0; bus2.btn_r = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  // Debounced level flips at edge k when the DB samples taken at edges
  // k-DB-1 .. k-2 all differ from it. A rise becomes pending one edge later.
  // A pulse may launch at any edge >= idle_from; the next one no earlier
  // than GAP+2 edges later.
  bit m_h[2][16];
  bit m_lvl[2], m_rise_d[2], m_pend[2];
  int m_t, m_idle_from;
  bit m_s, m_r, m_conf, m_ovr;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 16; i++) m_h[c][i] = 1'b0;
      m_lvl[c] = 0; m_rise_d[c] = 0; m_pend[c] = 0;
    end
    m_t = 0; m_idle_from = 0;
    m_s = 0; m_r = 0; m_conf = 0; m_ovr = 0;
  endtask

  task automatic model_step(input bit bs, input bit br);
    bit take[2];
    bit inb[2];
    bit all_diff;
    inb[0] = bs; inb[1] = br;
    take[0] = 0; take[1] = 0;
    m_s = 0; m_r = 0;
    if (m_t >= m_idle_from && (m_pend[0] || m_pend[1])) begin
      if (m_pend[0] && m_pend[1]) m_conf = 1;
      if (m_pend[0]) begin m_s = 1; take[0] = 1; end
      else           begin m_r = 1; take[1] = 1; end
      m_idle_from = m_t + GAP + 2;
    end
    for (int c = 0; c < 2; c++) begin
      bit np;
      np = m_pend[c];
      if (m_rise_d[c]) begin
        if (m_pend[c]) m_ovr = 1;
        else           np = 1;
      end
      if (take[c]) np = 0;
      m_pend[c] = np;
      for (int i = 15; i > 0; i--) m_h[c][i] = m_h[c][i-1];
      m_h[c][0] = inb[c];
      all_diff = 1;
      for (int i = 2; i <= DB + 1; i++)
        if (m_h[c][i] == m_lvl[c]) all_diff = 0;
      m_rise_d[c] = all_diff && !m_lvl[c];
      if (all_diff) m_lvl[c] = !m_lvl[c];
    end
    m_t++;
  endtask

  // ---------------- directed scenario table ----------------
  typedef struct {
    string nm;
    int    s_start, s_len, r_start, r_len;
    int    exp_s_edge, exp_s_cnt, exp_r_edge, exp_r_cnt;
    bit    exp_conf, exp_ovr;
  } scn_t;

  scn_t tbl[7];

  task automatic run_scn(input scn_t v);
    int s_edge, s_cnt, r_edge, r_cnt, both;
    s_edge = -1; s_cnt = 0; r_edge = -1; r_cnt = 0; both = 0;
    do_rst();
    for (int e = 0; e < 40; e++) begin
      bus1.btn_s = (e >= v.s_start) && (e < v.s_start + v.s_len);
      bus1.btn_r = (e >= v.r_start) && (e < v.r_start + v.r_len);
      @(posedge clk); #1;
      if (bus1.s) begin s_cnt++; if (s_edge < 0) s_edge = e; end
      if (bus1.r) begin r_cnt++; if (r_edge < 0) r_edge = e; end
      if (bus1.s && bus1.r) both++;
    end
    chk({v.nm, ".s_edge"},   s_edge, v.exp_s_edge);
    chk({v.nm, ".s_cnt"},    s_cnt,  v.exp_s_cnt);
    chk({v.nm, ".r_edge"},   r_edge, v.exp_r_edge);
    chk({v.nm, ".r_cnt"},    r_cnt,  v.exp_r_cnt);
    chk({v.nm, ".conflict"}, int'(bus1.conflict), int'(v.exp_conf));
    chk({v.nm, ".overrun"},  int'(bus1.overrun),  int'(v.exp_ovr));
    chk({v.nm, ".s_and_r"},  both, 0);
  endtask

  initial begin
    bit bs, br;
    int s_cnt, s_edge, s_edge2;

    tbl[0] = '{"s_hold",    10, 100, -1,   0, 17, 1, -1, 0, 0, 0};
    tbl[1] = '{"r_glitch3", -1,   0,  5,   3, -1, 0, -1, 0, 0, 0};
    tbl[2] = '{"both_hold", 10, 100, 10, 100, 17, 1, 21, 1, 1, 0};
    tbl[3] = '{"r_hold",    -1,   0,  3, 100, -1, 0, 10, 1, 0, 0};
    tbl[4] = '{"s_len_db",  10,   4, -1,   0, 17, 1, -1, 0, 0, 0};
    tbl[5] = '{"s_len_3",   10,   3, -1,   0, -1, 0, -1, 0, 0, 0};
    tbl[6] = '{"stagger",   10, 100, 14, 100, 17, 1, 21, 1, 0, 0};

    bus1.btn_s = 0; bus1.btn_r = 0; bus2.btn_s = 0; bus2.btn_r = 0;
    #1;
    chk("rst.s",        int'(bus1.s), 0);
    chk("rst.r",        int'(bus1.r), 0);
    chk("rst.conflict", int'(bus1.conflict), 0);
    chk("rst.overrun",  int'(bus1.overrun), 0);
    #20 rst = 1'b0;

    for (int i = 0; i < 7; i++) run_scn(tbl[i]);

    // Reset landing in PULSE_S aborts the pulse at once; a held button then
    // yields exactly one pulse after the normal latency.
    do_rst();
    bus1.btn_s = 1'b1;
    for (int e = 0; e < 8; e++) begin @(posedge clk); #1; end
    chk("abort.pre_s", int'(bus1.s), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort.s",        int'(bus1.s), 0);
    chk("abort.r",        int'(bus1.r), 0);
    chk("abort.conflict", int'(bus1.conflict), 0);
    chk("abort.overrun",  int'(bus1.overrun), 0);
    @(posedge clk); #1 rst = 1'b0;
    s_cnt = 0; s_edge = -1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      if (bus1.s) begin s_cnt++; if (s_edge < 0) s_edge = e; end
    end
    chk("abort.resume_edge", s_edge, 7);
    chk("abort.resume_cnt",  s_cnt, 1);

    // Overrun on the long-gap instance: press at 0..2 pulses at 5; press at
    // 8..10 pends during GAP; press at 13..15 rises while it is still pending.
    do_rst();
    s_cnt = 0; s_edge = -1; s_edge2 = -1;
    for (int e = 0; e < 40; e++) begin
      bus2.btn_s = (e <= 2) || (e >= 8 && e <= 10) || (e >= 13 && e <= 15);
      @(posedge clk); #1;
      if (bus2.s) begin
        s_cnt++;
        if (s_edge < 0) s_edge = e; else if (s_edge2 < 0) s_edge2 = e;
      end
    end
    chk("ovr.s_cnt",    s_cnt, 2);
    chk("ovr.s_edge1",  s_edge, 5);
    chk("ovr.s_edge2",  s_edge2, 19);
    chk("ovr.overrun",  int'(bus2.overrun), 1);
    chk("ovr.conflict", int'(bus2.conflict), 0);
    chk("ovr.r",        int'(bus2.r), 0);

    // Random buttons against the model, with occasional async resets.
    do_rst();
    model_reset();
    bs = 0; br = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 700 == 350) begin
        rst = 1'b1;
        model_reset();
        #1;
        chk("rnd_rst.s",  int'(bus1.s), 0);
        chk("rnd_rst.r",  int'(bus1.r), 0);
        chk("rnd_rst.flags", int'({bus1.conflict, bus1.overrun}), 0);
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b0;
      end
      if ($urandom_range(5) == 0) bs = !bs;
      if ($urandom_range(5) == 0) br = !br;
      bus1.btn_s = bs; bus1.btn_r = br;
      @(posedge clk);
      model_step(bs, br);
      #1;
      chk("rnd.s",        int'(bus1.s), int'(m_s));
      chk("rnd.r",        int'(bus1.r), int'(m_r));
      chk("rnd.conflict", int'(bus1.conflict), int'(m_conf));
      chk("rnd.overrun",  int'(bus1.overrun), int'(m_ovr));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_cmd_gen.md
SR_CMD_GEN -- requirements
Module: sr_cmd_gen

Interface
REQ-001 Parameter DB_CYCLES, default 4, consecutive cycles a synchronised input must differ from its debounced level before that level flips; legal range 1..2^CNT_W-1.
REQ-002 Parameter GAP_CYCLES, default 2, idle cycles forced after every issued pulse; legal range 1..2^CNT_W-1.
REQ-003 Parameter CNT_W, default 8, width of the debounce and gap counters.
REQ-004 Port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port btn_s  input  1  raw asynchronous set request (push-button level).
REQ-007 Port btn_r  input  1  raw asynchronous reset request (push-button level).
REQ-008 Port s  output  1  registered one-cycle set pulse to the downstream RS flip-flop.
REQ-009 Port r  output  1  registered one-cycle reset pulse to the downstream RS flip-flop.
REQ-010 Port conflict  output  1  sticky flag: both channels were pending in the same IDLE cycle.
REQ-011 Port overrun  output  1  sticky flag: a new edge arrived on a channel whose pending bit was already set.

Function
REQ-012 Each of btn_s and btn_r SHALL pass through a 2-flop synchroniser (sync1, sync2) before any other logic.
REQ-013 Per channel, the debounce counter SHALL increment each cycle sync2 differs from the debounced level, clear to 0 on any cycle they are equal, and when the increment would reach DB_CYCLES the debounced level SHALL toggle and the counter SHALL clear.
REQ-014 A 0->1 transition of a debounced level SHALL set that channel's pending bit on the following edge; a 1->0 transition SHALL have no effect.
REQ-015 If that channel's pending bit is already set, the new edge SHALL be dropped and overrun SHALL set.
REQ-016 FSM states: IDLE, PULSE_S, PULSE_R, GAP; s = 1 only in PULSE_S, r = 1 only in PULSE_R, both decoded from registered state; never both high.
REQ-017 IDLE: if pend_s, go PULSE_S and clear pend_s; else if pend_r, go PULSE_R and clear pend_r; else stay.
REQ-018 If pend_s and pend_r are both set in IDLE, set SHALL be served first, pend_r SHALL remain pending, and conflict SHALL set.
REQ-019 PULSE_S and PULSE_R SHALL last exactly one cycle, then go to GAP with the gap counter cleared.
REQ-020 GAP SHALL last exactly GAP_CYCLES cycles with s = r = 0, then return to IDLE; pending bits continue to accumulate during GAP.
REQ-021 Latency: with a clean input rising and sampled at edge E0, in IDLE with nothing pending, s (or r) SHALL be high for the cycle following edge E0+DB_CYCLES+3.
REQ-022 Minimum spacing between rising edges of consecutive pulses (s or r) SHALL be GAP_CYCLES+2 cycles.
REQ-023 Input glitches shorter than DB_CYCLES cycles (after synchronisation) SHALL produce no pulse and no pending bit.
REQ-024 conflict and overrun SHALL remain set until rst.

Reset
REQ-025 rst SHALL asynchronously clear sync flops, debounced levels, counters, pending bits, conflict and overrun, and force state IDLE, so s = r = 0 immediately.
REQ-026 rst asserted mid-pulse or mid-GAP SHALL abort the operation; pending requests are discarded.
REQ-027 A button held high through rst release SHALL produce exactly one pulse after normal debounce latency.

Verification
REQ-028 DB=4, GAP=2: btn_s 0->1 sampled at edge 10 and held -> s high in the cycle after edge 17 only, r stays 0, flags stay 0.
REQ-029 btn_r high for 3 cycles, then low -> no r pulse, pend_r never set.
REQ-030 btn_s and btn_r rise at the same edge and are held -> s pulse, then r pulse whose rising edge is 4 cycles later; conflict = 1.
REQ-031 Two clean btn_s presses whose debounced edges fall inside one GAP window -> one s pulse plus overrun = 1 if the second edge hits a set pend_s; otherwise two s pulses spaced >= 4 cycles.
REQ-032 rst asserted during PULSE_S -> s drops the same cycle; all flags and outputs 0; after release with btn_s held -> one s pulse after 7 cycles.
